// File: rtl/rom_load_buffer.sv
// Generic synchronous FIFO with a same-cycle flush that still admits the incoming word.
// Latency: a pushed word is visible at the head on the cycle after the push.
// Backpressure: full reflects the current count only; a pop in the same cycle does not free a slot.
module rom_load_buffer_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            flush,
  input  logic            push_vld,
  input  logic [W-1:0]    push_dat,
  input  logic            pop,
  output logic [W-1:0]    head_dat,
  output logic            empty,
  output logic            full,
  output logic [CNTW-1:0] count_nxt
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]    mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [PW-1:0]   wr_idx;
  logic [CNTW-1:0] count;
  logic            push_ok;
  logic            pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == CNTW'(DEPTH));
  assign head_dat = mem[rptr];

  // Accept/remove decisions and next occupancy; a flush restarts the ring at slot 0.
  always_comb begin
    push_ok = push_vld & (flush | ~full);
    pop_ok  = pop & ~empty & ~flush;
    wr_idx  = flush ? '0 : wptr;
    if (flush) begin
      count_nxt = push_ok ? CNTW'(1) : '0;
    end else begin
      count_nxt = count + CNTW'(push_ok) - CNTW'(pop_ok);
    end
  end

  // Pointer and occupancy registers; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        rptr <= '0;
        wptr <= push_ok ? PW'(1) : '0;
      end else begin
        if (push_ok) wptr <= wptr + PW'(1);
        if (pop_ok)  rptr <= rptr + PW'(1);
      end
    end
  end

  // Storage array; contents are only read when the count says they are valid.
  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wr_idx] <= push_dat;
  end
endmodule

// Queues ioctl ROM writes and drains them to the DDR write port over a toggle req/ack handshake.
// Latency: a push into an empty, idle buffer toggles wr_req two cycles later; back-to-back writes have no bubble.
// Backpressure: ioctl_wait is registered and asserts at HIWAT occupancy; strobes arriving while full are dropped and flagged.
module rom_load_buffer #(
  parameter int AW       = 25,
  parameter int DW       = 16,
  parameter int DEPTH    = 4,
  parameter int HIWAT    = 3,
  parameter int BYTESWAP = 1,
  parameter int CW       = 24
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [DW-1:0] ioctl_data,
  output logic          ioctl_wait,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          wr_req,
  input  logic          wr_ack,
  output logic          busy,
  output logic [CW-1:0] words_written,
  output logic          overflow
);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int NB   = DW / 8;
  localparam logic [CNTW-1:0] HIWAT_C = CNTW'(HIWAT);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } entry_t;

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t          state;
  state_t          state_nxt;
  entry_t          push_ent;
  entry_t          head_ent;
  logic [DW-1:0]   data_sw;
  logic [CNTW-1:0] count_nxt;
  logic            dl_q;
  logic            dl_rise;
  logic            push_req;
  logic            fifo_empty;
  logic            fifo_full;
  logic            head_vld;
  logic            ack_match;
  logic            issue;
  logic            ack_done;
  logic            skip_cnt;

  assign dl_rise   = ioctl_download & ~dl_q;
  assign push_req  = ioctl_wr & ioctl_download;
  assign ack_match = (wr_ack == wr_req);
  // Entries still in the ring during a restart belong to the old download.
  assign head_vld  = ~fifo_empty & ~dl_rise;
  assign busy      = (state != IDLE) | ~fifo_empty;
  assign push_ent  = {ioctl_addr, data_sw};

  // Optional byte reversal of the incoming data word.
  always_comb begin
    data_sw = ioctl_data;
    if (BYTESWAP != 0) begin
      for (int b = 0; b < NB; b++) begin
        data_sw[b*8 +: 8] = ioctl_data[(NB-1-b)*8 +: 8];
      end
    end
  end

  rom_load_buffer_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .flush     (dl_rise),
    .push_vld  (push_req),
    .push_dat  (push_ent),
    .pop       (issue),
    .head_dat  (head_ent),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count_nxt (count_nxt)
  );

  // Drain FSM state register.
  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Drain FSM decisions: issue the head when idle, or chain the next word on the ack cycle.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    ack_done  = 1'b0;
    case (state)
      IDLE: begin
        if (head_vld) begin
          issue     = 1'b1;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_match) begin
          ack_done = 1'b1;
          if (head_vld) issue = 1'b1;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write port, handshake, backpressure and progress/status registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      // Resync the toggle pair so leaving reset never launches a write.
      wr_req        <= wr_ack;
      wr_addr       <= '0;
      wr_data       <= '0;
      ioctl_wait    <= 1'b0;
      words_written <= '0;
      overflow      <= 1'b0;
      dl_q          <= 1'b0;
      skip_cnt      <= 1'b0;
    end else begin
      dl_q       <= ioctl_download;
      ioctl_wait <= (count_nxt >= HIWAT_C);

      if (issue) begin
        wr_addr <= head_ent.addr;
        wr_data <= head_ent.dat;
        wr_req  <= ~wr_req;
      end

      // A write already in flight at a restart completes but is not credited to the new download.
      if (dl_rise && state == WAIT_ACK && !ack_match) skip_cnt <= 1'b1;
      else if (ack_done)                              skip_cnt <= 1'b0;

      if (dl_rise) begin
        words_written <= '0;
      end else if (ack_done && !skip_cnt && words_written != '1) begin
        words_written <= words_written + 1'b1;
      end

      if (dl_rise)                          overflow <= 1'b0;
      else if (push_req && fifo_full)       overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rom_load_buffer.sv
// Directed bench for rom_load_buffer: DDR ack responder, write-capture monitor, hand-computed vectors.
// Latency: checks the two-cycle push-to-request path and drain completion with bounded waits.
// Backpressure: exercises ioctl_wait, overflow on a full ring, and restart/drain around download edges.
module tb_rom_load_buffer;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int CW = 24;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [DW-1:0] ioctl_data = '0;
  logic          ioctl_wait;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_req;
  logic          wr_ack = 1'b1;
  logic          busy;
  logic [CW-1:0] words_written;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] cap_addr [$];
  logic [DW-1:0] cap_data [$];
  logic          ack_en = 1'b0;
  int            ack_delay = 0;
  int            ack_cnt = 0;
  logic          req_seen;

  // Stimulus and hand-swapped expectations.
  logic [DW-1:0] t3_in  [8] = '{16'h1100, 16'h1201, 16'h1302, 16'h1403, 16'h1504, 16'h1605, 16'h1706, 16'h1807};
  logic [DW-1:0] t3_exp [8] = '{16'h0011, 16'h0112, 16'h0213, 16'h0314, 16'h0415, 16'h0516, 16'h0617, 16'h0718};
  // The first word is issued at once, so occupancy reaches 3 only on the 4th push.
  logic          t3_wait [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [DW-1:0] t4_in  [5] = '{16'hC001, 16'hC002, 16'hC003, 16'hC004, 16'hC005};
  logic [DW-1:0] t4_exp [5] = '{16'h55AA, 16'h01C0, 16'h02C0, 16'h03C0, 16'h04C0};
  logic          t4_ovf [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [DW-1:0] t5_in  [4] = '{16'h2021, 16'h2223, 16'h2425, 16'h2627};
  logic [DW-1:0] t5_exp [4] = '{16'h2120, 16'h2322, 16'h2524, 16'h2726};

  always #5 clk_sys = ~clk_sys;

  rom_load_buffer dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .ioctl_wait     (ioctl_wait),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_req         (wr_req),
    .wr_ack         (wr_ack),
    .busy           (busy),
    .words_written  (words_written),
    .overflow       (overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Capture every issued write, then play the DDR side with a programmable ack delay.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        req_seen = wr_req;
      end else if (wr_req !== req_seen) begin
        cap_addr.push_back(wr_addr);
        cap_data.push_back(wr_data);
        req_seen = wr_req;
      end
      if (!reset && ack_en && (wr_req !== wr_ack)) begin
        if (ack_cnt >= ack_delay) begin
          wr_ack  = wr_req;
          ack_cnt = 0;
        end else begin
          ack_cnt++;
        end
      end else begin
        ack_cnt = 0;
      end
    end
  end

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    repeat (2) @(negedge clk_sys);
    check({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  task automatic new_window();
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    cap_addr.delete();
    cap_data.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with wr_ack high resyncs wr_req, status cleared
    repeat (3) @(negedge clk_sys);
    check("rst_wr_req", 64'(wr_req), 64'(1));
    check("rst_wait", 64'(ioctl_wait), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_words", 64'(words_written), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    check("rst_addr", 64'(wr_addr), 64'(0));
    check("rst_data", 64'(wr_data), 64'(0));
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_no_write", 64'(wr_req), 64'(1));
    check("rst_no_cap", 64'(cap_data.size()), 64'(0));

    // 2: single write, byte-swapped, ack three cycles later
    ack_en    = 1'b1;
    ack_delay = 3;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    ioctl_addr = 25'h10;
    ioctl_data = 16'h1234;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    check("t2_lat_n1_req", 64'(wr_req), 64'(1));
    check("t2_lat_n1_busy", 64'(busy), 64'(1));
    @(negedge clk_sys);
    check("t2_lat_n2_req", 64'(wr_req), 64'(0));
    check("t2_addr", 64'(wr_addr), 64'(25'h10));
    check("t2_data", 64'(wr_data), 64'(16'h3412));
    wait_idle("t2");
    check("t2_words", 64'(words_written), 64'(1));
    check("t2_ncap", 64'(cap_data.size()), 64'(1));

    // 3: eight writes with ack held off, then the HPS obeys ioctl_wait
    new_window();
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(AW'(32'h100 + i), t3_in[i]);
      check($sformatf("t3_wait%0d", i), 64'(ioctl_wait), 64'(t3_wait[i]));
    end
    ack_en    = 1'b1;
    ack_delay = 1;
    begin
      int idx = 4;
      int guard = 0;
      while (idx < 8 && guard < 300) begin
        if (!ioctl_wait) begin
          ioctl_addr = AW'(32'h100 + idx);
          ioctl_data = t3_in[idx];
          ioctl_wr   = 1'b1;
          idx++;
        end else begin
          ioctl_wr = 1'b0;
        end
        @(negedge clk_sys);
        guard++;
      end
      ioctl_wr = 1'b0;
      check("t3_pushed", 64'(idx), 64'(8));
    end
    wait_idle("t3");
    check("t3_ncap", 64'(cap_data.size()), 64'(8));
    for (int i = 0; i < 8 && i < cap_data.size(); i++) begin
      check($sformatf("t3_addr%0d", i), 64'(cap_addr[i]), 64'(32'h100 + i));
      check($sformatf("t3_data%0d", i), 64'(cap_data[i]), 64'(t3_exp[i]));
    end
    check("t3_ovf", 64'(overflow), 64'(0));
    check("t3_words", 64'(words_written), 64'(8));

    // 4: one write in flight, then five strobes into the 4-deep ring
    new_window();
    ack_en = 1'b0;
    push(25'h200, 16'hAA55);
    repeat (2) @(negedge clk_sys);
    check("t4_inflight", 64'(wr_data), 64'(16'h55AA));
    for (int i = 0; i < 5; i++) begin
      push(AW'(32'h201 + i), t4_in[i]);
      check($sformatf("t4_ovf%0d", i), 64'(overflow), 64'(t4_ovf[i]));
    end
    check("t4_wait", 64'(ioctl_wait), 64'(1));
    ack_en    = 1'b1;
    ack_delay = 0;
    wait_idle("t4");
    check("t4_ncap", 64'(cap_data.size()), 64'(5));
    for (int i = 0; i < 5 && i < cap_data.size(); i++) begin
      check($sformatf("t4_data%0d", i), 64'(cap_data[i]), 64'(t4_exp[i]));
    end
    check("t4_words", 64'(words_written), 64'(5));
    check("t4_ovf_sticky", 64'(overflow), 64'(1));

    // 5: download drops with words queued; they still drain, later strobes ignored
    new_window();
    check("t5_ovf_clr", 64'(overflow), 64'(0));
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) push(AW'(32'h300 + i), t5_in[i]);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    push(25'h3FF, 16'hDEAD);
    check("t5_busy", 64'(busy), 64'(1));
    ack_en    = 1'b1;
    ack_delay = 2;
    wait_idle("t5");
    check("t5_ncap", 64'(cap_data.size()), 64'(4));
    for (int i = 0; i < 4 && i < cap_data.size(); i++) begin
      check($sformatf("t5_data%0d", i), 64'(cap_data[i]), 64'(t5_exp[i]));
    end
    check("t5_words", 64'(words_written), 64'(4));
    push(25'h3FE, 16'hBEEF);
    repeat (5) @(negedge clk_sys);
    check("t5_ign_busy", 64'(busy), 64'(0));
    check("t5_ign_ncap", 64'(cap_data.size()), 64'(4));

    // 6: restart the download while a write awaits its ack
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    cap_addr.delete();
    cap_data.delete();
    check("t6_words_clr", 64'(words_written), 64'(0));
    ack_delay = 0;
    push(25'h400, 16'h3031);
    wait_idle("t6a");
    check("t6_words_pre", 64'(words_written), 64'(1));
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) push(AW'(32'h401 + i), 16'h4041 + DW'(i * 16'h0202));
    @(negedge clk_sys);
    check("t6_busy", 64'(busy), 64'(1));
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    check("t6_words_rst", 64'(words_written), 64'(0));
    ack_en = 1'b1;
    wait_idle("t6b");
    check("t6_words_uncounted", 64'(words_written), 64'(0));
    check("t6_ncap", 64'(cap_data.size()), 64'(2));
    if (cap_data.size() >= 2) check("t6_inflight", 64'(cap_data[1]), 64'(16'h4140));
    push(25'h410, 16'h5051);
    wait_idle("t6c");
    check("t6_words_post", 64'(words_written), 64'(1));
    check("t6_ncap_post", 64'(cap_data.size()), 64'(3));
    if (cap_data.size() >= 3) begin
      check("t6_post_data", 64'(cap_data[2]), 64'(16'h5150));
      check("t6_post_addr", 64'(cap_addr[2]), 64'(25'h410));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
